// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per execution unit, round-robin
// drain of one buffered result per cycle onto a registered broadcast bus.
// A mispredict flush empties every buffer and squashes the pending broadcast.
module cdb_arbiter #(
    parameter int NREQ  = 3,
    parameter int ROBBW = 5,
    parameter int PTRW  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    jump_wrong,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*ROBBW-1:0]   req_rob_id,
    input  logic [NREQ*32-1:0]      req_val,
    output logic [NREQ-1:0]         req_ready,
    output logic                    ex_cdb_flag,
    output logic [ROBBW-1:0]        ex_cdb_rob_id,
    output logic [31:0]             ex_cdb_val,
    output logic                    busy
);

    logic [NREQ-1:0]  buf_valid_q, buf_valid_d;
    logic [ROBBW-1:0] buf_id_q  [NREQ];
    logic [ROBBW-1:0] buf_id_d  [NREQ];
    logic [31:0]      buf_val_q [NREQ];
    logic [31:0]      buf_val_d [NREQ];
    logic [PTRW-1:0]  rr_ptr_q, rr_ptr_d;
    logic             cdb_flag_q, cdb_flag_d;
    logic [ROBBW-1:0] cdb_id_q, cdb_id_d;
    logic [31:0]      cdb_val_q, cdb_val_d;

    logic [NREQ-1:0]  grant;
    logic             gnt_found;
    logic [PTRW-1:0]  gnt_idx;

    // Position k steps after the pointer, wrapped modulo NREQ.
    function automatic logic [PTRW-1:0] wrap_idx(logic [PTRW-1:0] p, int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[PTRW-1:0];
    endfunction

    // Round-robin grant: first occupied buffer at or after the pointer.
    always_comb begin
        grant     = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && buf_valid_q[wrap_idx(rr_ptr_q, k)]) begin
                gnt_found                       = 1'b1;
                gnt_idx                         = wrap_idx(rr_ptr_q, k);
                grant[wrap_idx(rr_ptr_q, k)]    = 1'b1;
            end
        end
    end

    // A buffer can take a new result when empty or when it drains this edge.
    assign req_ready = {NREQ{rdy & ~rst & ~jump_wrong}} & (~buf_valid_q | grant);

    // Next state: flush beats stall, stall beats normal drain/accept.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_id_d    = buf_id_q;
        buf_val_d   = buf_val_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_flag_d  = cdb_flag_q;
        cdb_id_d    = cdb_id_q;
        cdb_val_d   = cdb_val_q;
        if (jump_wrong) begin
            buf_valid_d = '0;
            cdb_flag_d  = 1'b0;
            rr_ptr_d    = '0;
        end else if (rdy) begin
            if (gnt_found) begin
                cdb_flag_d           = 1'b1;
                cdb_id_d             = buf_id_q[gnt_idx];
                cdb_val_d            = buf_val_q[gnt_idx];
                buf_valid_d[gnt_idx] = 1'b0;
                rr_ptr_d = (gnt_idx == PTRW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                cdb_flag_d = 1'b0;
            end
            // Accept after drain so a same-edge reload keeps the buffer full.
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    buf_valid_d[i] = 1'b1;
                    buf_id_d[i]    = req_rob_id[i*ROBBW +: ROBBW];
                    buf_val_d[i]   = req_val[i*32 +: 32];
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= '0;
            rr_ptr_q    <= '0;
            cdb_flag_q  <= 1'b0;
            cdb_id_q    <= '0;
            cdb_val_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                buf_id_q[i]  <= '0;
                buf_val_q[i] <= '0;
            end
        end else begin
            buf_valid_q <= buf_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_flag_q  <= cdb_flag_d;
            cdb_id_q    <= cdb_id_d;
            cdb_val_q   <= cdb_val_d;
            for (int i = 0; i < NREQ; i++) begin
                buf_id_q[i]  <= buf_id_d[i];
                buf_val_q[i] <= buf_val_d[i];
            end
        end
    end

    assign ex_cdb_flag   = cdb_flag_q;
    assign ex_cdb_rob_id = cdb_id_q;
    assign ex_cdb_val    = cdb_val_q;
    assign busy          = |buf_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Table-driven bench for cdb_arbiter (NREQ=3, ROBBW=5). Each table row is one
// cycle: inputs are applied after the falling edge, outputs are compared 1ns
// later (registered outputs reflect the previous rising edge), then the
// rising edge commits the row.
module tb_cdb_arbiter;
    localparam int NREQ  = 3;
    localparam int ROBBW = 5;
    localparam int NVEC  = 51;

    logic                  clk = 1'b0;
    logic                  rst, rdy, jump_wrong;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ROBBW-1:0] req_rob_id;
    logic [NREQ*32-1:0]    req_val;
    logic [NREQ-1:0]       req_ready;
    logic                  ex_cdb_flag;
    logic [ROBBW-1:0]      ex_cdb_rob_id;
    logic [31:0]           ex_cdb_val;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NREQ(NREQ), .ROBBW(ROBBW), .PTRW(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .req_valid(req_valid), .req_rob_id(req_rob_id), .req_val(req_val),
        .req_ready(req_ready), .ex_cdb_flag(ex_cdb_flag),
        .ex_cdb_rob_id(ex_cdb_rob_id), .ex_cdb_val(ex_cdb_val), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic       jw;
        logic [2:0] v;
        logic [4:0] id0, id1, id2;
        logic       eflag;
        logic [4:0] eid;
        logic       ebusy;
        logic [2:0] erdy;
    } vec_t;

    vec_t vt [NVEC];

    // Result value carried with each tag, so a value from the wrong buffer shows.
    function automatic logic [31:0] fval(logic [4:0] id);
        return 32'h0000_1234 ^ {11'h0, id, 16'h0};
    endfunction

    function automatic vec_t mk(logic r, logic rd, logic jw, logic [2:0] v,
                                logic [4:0] i0, logic [4:0] i1, logic [4:0] i2,
                                logic ef, logic [4:0] eid, logic eb, logic [2:0] er);
        vec_t t;
        t.rst = r; t.rdy = rd; t.jw = jw; t.v = v;
        t.id0 = i0; t.id1 = i1; t.id2 = i2;
        t.eflag = ef; t.eid = eid; t.ebusy = eb; t.erdy = er;
        return t;
    endfunction

    task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(logic r, logic rd, logic jw, logic [2:0] v,
                         logic [4:0] i0, logic [4:0] i1, logic [4:0] i2);
        rst = r; rdy = rd; jump_wrong = jw; req_valid = v;
        req_rob_id = {i2, i1, i0};
        req_val    = {fval(i2), fval(i1), fval(i0)};
    endtask

    // Tag 0 means "no tag" and must never be presented.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++)
                assert (!(req_valid[i] && req_rob_id[i*ROBBW +: ROBBW] == 5'd0))
                    else $error("illegal rob tag 0 on requester %0d", i);
        end
    end

    initial begin
        //           rst rdy jw  v       id0 id1 id2  flag eid busy ready
        // reset then idle
        vt[0]  = mk(0, 1, 0, 3'b000,  0,  0,  0,  0,  0, 0, 3'b111);
        // single requester, then back-to-back 5,6,7
        vt[1]  = mk(0, 1, 0, 3'b001,  5,  0,  0,  0,  0, 0, 3'b111);
        vt[2]  = mk(0, 1, 0, 3'b000,  0,  0,  0,  0,  0, 1, 3'b111);
        vt[3]  = mk(0, 1, 0, 3'b000,  0,  0,  0,  1,  5, 0, 3'b111);
        vt[4]  = mk(0, 1, 0, 3'b000,  0,  0,  0,  0,  5, 0, 3'b111);
        vt[5]  = mk(0, 1, 0, 3'b001,  5,  0,  0,  0,  5, 0, 3'b111);
        vt[6]  = mk(0, 1, 0, 3'b001,  6,  0,  0,  0,  5, 1, 3'b111);
        vt[7]  = mk(0, 1, 0, 3'b001,  7,  0,  0,  1,  5, 1, 3'b111);
        vt[8]  = mk(0, 1, 0, 3'b000,  0,  0,  0,  1,  6, 1, 3'b111);
        vt[9]  = mk(0, 1, 0, 3'b000,  0,  0,  0,  1,  7, 0, 3'b111);
        // grant requester 2 so the pointer wraps back to 0
        vt[10] = mk(0, 1, 0, 3'b100,  0,  0,  9,  0,  7, 0, 3'b111);
        vt[11] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0,  7, 1, 3'b111);
        // simultaneous accept of 1,2,3 with pointer at 0
        vt[12] = mk(0, 1, 0, 3'b111,  1,  2,  3,  1,  9, 0, 3'b111);
        vt[13] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0,  9, 1, 3'b001);
        vt[14] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1,  1, 1, 3'b011);
        vt[15] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1,  2, 1, 3'b111);
        vt[16] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1,  3, 0, 3'b111);
        vt[17] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0,  3, 0, 3'b111);
        // fairness: requesters 0 and 2 kept busy, grants 0,2,0,2,0,2
        vt[18] = mk(0, 1, 0, 3'b101, 10,  0, 20,  0,  3, 0, 3'b111);
        vt[19] = mk(0, 1, 0, 3'b101, 11,  0, 21,  0,  3, 1, 3'b011);
        vt[20] = mk(0, 1, 0, 3'b101, 12,  0, 21,  1, 10, 1, 3'b110);
        vt[21] = mk(0, 1, 0, 3'b101, 12,  0, 22,  1, 20, 1, 3'b011);
        vt[22] = mk(0, 1, 0, 3'b101, 13,  0, 22,  1, 11, 1, 3'b110);
        vt[23] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1, 21, 1, 3'b011);
        vt[24] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1, 12, 1, 3'b111);
        vt[25] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1, 22, 0, 3'b111);
        // flush with buffers 1 and 2 full and pointer at 1
        vt[26] = mk(0, 1, 0, 3'b111, 17, 14, 24,  0, 22, 0, 3'b111);
        vt[27] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0, 22, 1, 3'b001);
        vt[28] = mk(0, 1, 1, 3'b001, 15,  0,  0,  1, 17, 1, 3'b000);
        vt[29] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0, 17, 0, 3'b111);
        vt[30] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0, 17, 0, 3'b111);
        // pointer must be 0 after the flush: requester 0 wins over 1
        vt[31] = mk(0, 1, 0, 3'b011, 18, 19,  0,  0, 17, 0, 3'b111);
        vt[32] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0, 17, 1, 3'b101);
        vt[33] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1, 18, 1, 3'b111);
        vt[34] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1, 19, 0, 3'b111);
        // stall with tag 4 on the bus and buffers 0,1 full
        vt[35] = mk(0, 1, 0, 3'b111,  1,  2,  4,  0, 19, 0, 3'b111);
        vt[36] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0, 19, 1, 3'b100);
        vt[37] = mk(0, 0, 0, 3'b100,  0,  0,  6,  1,  4, 1, 3'b000);
        vt[38] = mk(0, 0, 0, 3'b100,  0,  0,  6,  1,  4, 1, 3'b000);
        vt[39] = mk(0, 0, 0, 3'b100,  0,  0,  6,  1,  4, 1, 3'b000);
        vt[40] = mk(0, 1, 0, 3'b100,  0,  0,  6,  1,  4, 1, 3'b101);
        vt[41] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1,  1, 1, 3'b011);
        vt[42] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1,  2, 1, 3'b111);
        vt[43] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1,  6, 0, 3'b111);
        // reset while buffers are full
        vt[44] = mk(0, 1, 0, 3'b111,  7,  8,  9,  0,  6, 0, 3'b111);
        vt[45] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0,  6, 1, 3'b001);
        vt[46] = mk(1, 1, 0, 3'b000,  0,  0,  0,  1,  7, 1, 3'b000);
        vt[47] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0,  0, 0, 3'b111);
        vt[48] = mk(0, 1, 0, 3'b010,  0, 11,  0,  0,  0, 0, 3'b111);
        vt[49] = mk(0, 1, 0, 3'b000,  0,  0,  0,  0,  0, 1, 3'b111);
        vt[50] = mk(0, 1, 0, 3'b000,  0,  0,  0,  1, 11, 0, 3'b111);

        drive(1, 1, 0, 3'b000, 0, 0, 0);
        repeat (2) @(posedge clk);

        for (int r = 0; r < NVEC; r++) begin
            @(negedge clk);
            drive(vt[r].rst, vt[r].rdy, vt[r].jw, vt[r].v, vt[r].id0, vt[r].id1, vt[r].id2);
            #1;
            chk("ex_cdb_flag",   r, 32'(ex_cdb_flag),   32'(vt[r].eflag));
            chk("ex_cdb_rob_id", r, 32'(ex_cdb_rob_id), 32'(vt[r].eid));
            chk("ex_cdb_val",    r, ex_cdb_val,
                (vt[r].eid == 5'd0) ? 32'h0 : fval(vt[r].eid));
            chk("busy",          r, 32'(busy),          32'(vt[r].ebusy));
            chk("req_ready",     r, 32'(req_ready),     32'(vt[r].erdy));
        end

        // Lone requester streaming one result per cycle: tags 20..27 on
        // requester 1 appear on the bus two samples after being presented.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) drive(0, 1, 0, 3'b010, 0, 5'(20 + c), 0);
            else       drive(0, 1, 0, 3'b000, 0, 0, 0);
            #1;
            chk("stream_ready", 100 + c, 32'(req_ready[1]), 32'd1);
            chk("stream_flag",  100 + c, 32'(ex_cdb_flag), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                chk("stream_id",  100 + c, 32'(ex_cdb_rob_id), 32'(20 + c - 2));
                chk("stream_val", 100 + c, ex_cdb_val, fval(5'(20 + c - 2)));
            end
        end
        @(negedge clk);
        #1;
        chk("stream_end_flag", 110, 32'(ex_cdb_flag), 32'd0);
        chk("stream_end_busy", 110, 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
